hex_display_scanner: RTL and testbench



---
 rtl/hex_display_pkg.sv | 28 ++
 rtl/hex_to_7seg.sv | 16 +
 rtl/hex_display_scanner.sv | 160 ++++++++++++++++
 tb/tb_hex_display_scanner.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// hex_display_pkg: register map, CONTROL bit positions and seven-segment constants
// shared by the hex display scanner and its decoder. Revision 1.0.
`default_nettype none

package hex_display_pkg;

  localparam logic [1:0] ADDR_VALUE   = 2'd0;
  localparam logic [1:0] ADDR_CONTROL = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_BLINK   = 2'd3;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_LZS_BIT    = 1;
  localparam int CTRL_DP_LSB     = 4;

  // Active-high {g,f,e,d,c,b,a}; entry 15 first so SEG7_TABLE[n] is digit n.
  localparam logic [15:0][6:0] SEG7_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [3:0] DIGITS_OFF_N   = 4'hF;
  localparam logic [7:0] SEGMENTS_OFF_N = 8'hFF;
  localparam logic [6:0] SEG_BLANK_N    = 7'h7F;

endpackage

`default_nettype wire

// File: rtl/hex_to_7seg.sv
// hex_to_7seg: combinational nibble to active-high seven-segment pattern decoder.
// Revision 1.0.
`default_nettype none

module hex_to_7seg
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  assign segs = SEG7_TABLE[nibble];

endmodule

`default_nettype wire

// File: rtl/hex_display_scanner.sv
// hex_display_scanner: Avalon-MM 4-digit multiplexed seven-segment scanner with
// anti-ghost blanking and frame-synchronous update. Optional blink: HEX_DISPLAY_BLINK_EN. Revision 1.0.
`default_nettype none

module hex_display_scanner
  import hex_display_pkg::*;
#(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [3:0]  digit_sel_n,
  output logic [7:0]  segments_n
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic [15:0]      shadow;
  logic [15:0]      live;
  logic             ctrl_enable;
  logic             ctrl_lzs;
  logic [3:0]       dp_mask;
  logic             pending;
  logic [CNT_W-1:0] slot_cnt;
  logic [1:0]       digit_idx;
  logic             blink_off;
  logic [31:0]      blink_rd;

  logic wr_en;
  logic value_wr;
  logic ctrl_wr;
  logic disable_now;
  logic frame_start;
  logic suppress;
  logic [3:0] cur_nibble;
  logic [6:0] cur_segs;
  logic unused_wdata;

  assign wr_en    = chipselect & ~write_n;
  assign value_wr = wr_en & (address == ADDR_VALUE);
  assign ctrl_wr  = wr_en & (address == ADDR_CONTROL);

  // A write that clears enable darkens the display and parks the scan on the same edge.
  assign disable_now = ~ctrl_enable | (ctrl_wr & ~writedata[CTRL_ENABLE_BIT]);
  assign frame_start = ctrl_enable & (slot_cnt == '0) & (digit_idx == 2'd0);

  assign cur_nibble = live[{digit_idx, 2'b00} +: 4];
  assign suppress   = ctrl_lzs & (digit_idx != 2'd0) & ((live >> {digit_idx, 2'b00}) == 16'h0);
  assign unused_wdata = ^{writedata[31:16], writedata[3:2]};

  hex_to_7seg u_hex_to_7seg (
    .nibble (cur_nibble),
    .segs   (cur_segs)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow      <= 16'h0;
      live        <= 16'h0;
      ctrl_enable <= 1'b0;
      ctrl_lzs    <= 1'b0;
      dp_mask     <= 4'h0;
      pending     <= 1'b0;
    end else begin
      if (value_wr) shadow <= writedata[15:0];
      if (ctrl_wr) begin
        ctrl_enable <= writedata[CTRL_ENABLE_BIT];
        ctrl_lzs    <= writedata[CTRL_LZS_BIT];
        dp_mask     <= writedata[CTRL_DP_LSB +: 4];
      end
      // live samples shadow before a coincident write lands, so that write stays pending.
      if (frame_start) live <= shadow;
      if (value_wr)         pending <= 1'b1;
      else if (frame_start) pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (disable_now) begin
      slot_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (slot_cnt == CNT_W'(CLK_DIV - 1)) begin
      slot_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      slot_cnt  <= slot_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit_sel_n <= DIGITS_OFF_N;
      segments_n  <= SEGMENTS_OFF_N;
    end else if (disable_now || blink_off || (slot_cnt < CNT_W'(BLANK_CYCLES))) begin
      digit_sel_n <= DIGITS_OFF_N;
      segments_n  <= SEGMENTS_OFF_N;
    end else begin
      digit_sel_n <= ~(4'b0001 << digit_idx);
      segments_n  <= {~dp_mask[digit_idx], suppress ? SEG_BLANK_N : ~cur_segs};
    end
  end

`ifdef HEX_DISPLAY_BLINK_EN
  logic [7:0] blink_period;
  logic [7:0] frame_cnt;
  logic       blink_state;
  logic       blink_wr;

  assign blink_wr  = wr_en & (address == ADDR_BLINK);
  assign blink_off = blink_state;
  assign blink_rd  = {24'h0, blink_period};

  // frame_cnt counts frame starts since the last toggle, so each phase lasts exactly one period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_period <= 8'h0;
      frame_cnt    <= 8'h0;
      blink_state  <= 1'b0;
    end else begin
      if (blink_wr) blink_period <= writedata[7:0];
      if (blink_period == 8'h0) begin
        frame_cnt   <= 8'h0;
        blink_state <= 1'b0;
      end else if (frame_start) begin
        if (frame_cnt >= blink_period) begin
          blink_state <= ~blink_state;
          frame_cnt   <= 8'h1;
        end else begin
          frame_cnt   <= frame_cnt + 8'h1;
        end
      end
    end
  end
`else
  assign blink_off = 1'b0;
  assign blink_rd  = 32'h0;
`endif

  always_comb begin
    readdata = 32'h0;
    case (address)
      ADDR_VALUE:   readdata = {16'h0, shadow};
      ADDR_CONTROL: readdata = {24'h0, dp_mask, 2'b00, ctrl_lzs, ctrl_enable};
      ADDR_STATUS:  readdata = {23'h0, pending, 6'h0, digit_idx};
      default:      readdata = blink_rd;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_hex_display_scanner.sv
// tb_hex_display_scanner: directed plus randomized bench with a frame-level reference
// model of the hex display scanner (CLK_DIV=8, BLANK_CYCLES=2). Revision 1.0.
`default_nettype none

module tb_hex_display_scanner;

  localparam int CLK_DIV = 8;
  localparam int BLANK   = 2;
  localparam int FRAME   = 4 * CLK_DIV;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic [3:0]  digit_sel_n;
  logic [7:0]  segments_n;

  hex_display_scanner #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .digit_sel_n (digit_sel_n),
    .segments_n  (segments_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit check_on = 1'b0;

  // Reference model: scan position is derived from the cycle count since enable.
  logic [15:0] m_shadow, m_live;
  logic        m_en, m_lzs, m_pending, m_blink;
  logic [3:0]  m_dp;
  logic [7:0]  m_period, m_fcnt;
  int          m_t;
  logic [3:0]  exp_sel;
  logic [7:0]  exp_seg;

  function automatic logic [6:0] hex_low(input logic [3:0] n);
    case (n)
      4'h0: hex_low = 7'h40; 4'h1: hex_low = 7'h79; 4'h2: hex_low = 7'h24; 4'h3: hex_low = 7'h30;
      4'h4: hex_low = 7'h19; 4'h5: hex_low = 7'h12; 4'h6: hex_low = 7'h02; 4'h7: hex_low = 7'h78;
      4'h8: hex_low = 7'h00; 4'h9: hex_low = 7'h10; 4'hA: hex_low = 7'h08; 4'hB: hex_low = 7'h03;
      4'hC: hex_low = 7'h46; 4'hD: hex_low = 7'h21; 4'hE: hex_low = 7'h06; default: hex_low = 7'h0E;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    int idx;
    idx = (m_t / CLK_DIV) % 4;
    case (a)
      2'd0:    model_read = {16'h0, m_shadow};
      2'd1:    model_read = {24'h0, m_dp, 2'b00, m_lzs, m_en};
      2'd2:    model_read = {23'h0, m_pending, 6'h0, 2'(idx)};
`ifdef HEX_DISPLAY_BLINK_EN
      default: model_read = {24'h0, m_period};
`else
      default: model_read = 32'h0;
`endif
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin : model
    logic wr, clearing, fs;
    int cnt, idx;
    logic [15:0] upper;
    if (!reset_n) begin
      m_shadow <= 16'h0; m_live <= 16'h0; m_en <= 1'b0; m_lzs <= 1'b0;
      m_pending <= 1'b0; m_blink <= 1'b0; m_dp <= 4'h0; m_period <= 8'h0;
      m_fcnt <= 8'h0; m_t <= 0; exp_sel <= 4'hF; exp_seg <= 8'hFF;
    end else begin
      wr       = chipselect && !write_n;
      clearing = wr && (address == 2'd1) && !writedata[0];
      cnt      = m_t % CLK_DIV;
      idx      = (m_t / CLK_DIV) % 4;
      upper    = m_live >> (4 * idx);
      if (!m_en || clearing || m_blink || cnt < BLANK) begin
        exp_sel <= 4'hF;
        exp_seg <= 8'hFF;
      end else begin
        exp_sel <= 4'hF ^ (4'b0001 << idx);
        if (m_lzs && idx > 0 && upper == 16'h0)
          exp_seg <= {~m_dp[idx], 7'h7F};
        else
          exp_seg <= {~m_dp[idx], hex_low(upper[3:0])};
      end
      fs = m_en && (m_t % FRAME == 0);
`ifdef HEX_DISPLAY_BLINK_EN
      if (m_period == 8'h0) begin
        m_blink <= 1'b0; m_fcnt <= 8'h0;
      end else if (fs) begin
        if (m_fcnt >= m_period) begin m_blink <= ~m_blink; m_fcnt <= 8'h1; end
        else m_fcnt <= m_fcnt + 8'h1;
      end
      if (wr && address == 2'd3) m_period <= writedata[7:0];
`endif
      if (fs) m_live <= m_shadow;
      if (wr && address == 2'd0) begin
        m_shadow <= writedata[15:0];
        m_pending <= 1'b1;
      end else if (fs) begin
        m_pending <= 1'b0;
      end
      m_t <= (!m_en || clearing) ? 0 : m_t + 1;
      if (wr && address == 2'd1) begin
        m_en <= writedata[0]; m_lzs <= writedata[1]; m_dp <= writedata[7:4];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_on) begin
      check("digit_sel_n", {28'h0, digit_sel_n}, {28'h0, exp_sel});
      check("segments_n", {24'h0, segments_n}, {24'h0, exp_seg});
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk); #1;
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a);
    @(negedge clk); #1;
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1 check("readdata_model", readdata, model_read(a));
    chipselect = 1'b0;
  endtask

  task automatic read_lit(input logic [1:0] a, input string name, input logic [31:0] mask,
                          input logic [31:0] exp);
    @(negedge clk); #1;
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1 check(name, readdata & mask, exp);
    chipselect = 1'b0;
  endtask

  task automatic wait_sel(input logic [3:0] target, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk); #2;
      if (digit_sel_n == target) found = 1'b1;
    end
    if (!found) begin
      errors++;
      $display("FAIL %s: timeout waiting for digit_sel_n=%0h, last %0h", name, target, digit_sel_n);
    end
  endtask

  int n;
  int lit;
  logic [3:0] prev;
  int r;
  logic [1:0] ra;
  logic [31:0] rd;

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_sel", {28'h0, digit_sel_n}, 32'hF);
    check("reset_seg", {24'h0, segments_n}, 32'hFF);
    @(negedge clk);
    reset_n = 1'b1;
    check_on = 1'b1;
    for (int a = 0; a < 4; a++) read_lit(2'(a), "reset_reg", 32'hFFFF_FFFF, 32'h0);
    repeat (4) @(negedge clk);

    // Basic scan of 0x1234
    bus_write(2'd0, 32'h1234);
    bus_write(2'd1, 32'h1);
    wait_sel(4'b1110, "digit0_1234");
    check("digit0_seg", {24'h0, segments_n}, 32'h99);
    n = 0; prev = digit_sel_n;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #2;
      n++;
      if (prev != 4'b1110 && digit_sel_n == 4'b1110) break;
      prev = digit_sel_n;
    end
    check("frame_period", n, FRAME);
    wait_sel(4'b1101, "digit1_1234");
    check("digit1_seg", {24'h0, segments_n}, 32'hB0);

    // Mid-frame update is deferred to the next frame start
    bus_write(2'd0, 32'hABCD);
    read_lit(2'd2, "status_pending_set", 32'h100, 32'h100);
    wait_sel(4'b0111, "digit3_old");
    check("digit3_old_seg", {24'h0, segments_n}, 32'hF9);
    wait_sel(4'b1110, "digit0_new");
    check("digit0_new_seg", {24'h0, segments_n}, 32'hA1);
    read_lit(2'd2, "status_pending_clr", 32'h100, 32'h0);

    // Leading-zero suppression
    bus_write(2'd0, 32'h0050);
    bus_write(2'd1, 32'h3);
    repeat (40) @(negedge clk);
    wait_sel(4'b1110, "lzs_d0");
    check("lzs_d0_seg", {24'h0, segments_n}, 32'hC0);
    wait_sel(4'b1101, "lzs_d1");
    check("lzs_d1_seg", {24'h0, segments_n}, 32'h92);
    wait_sel(4'b1011, "lzs_d2");
    check("lzs_d2_seg", {24'h0, segments_n}, 32'hFF);
    wait_sel(4'b0111, "lzs_d3");
    check("lzs_d3_seg", {24'h0, segments_n}, 32'hFF);

    // Decimal point on digit 1, then disable mid-slot
    bus_write(2'd1, 32'h21);
    repeat (40) @(negedge clk);
    wait_sel(4'b1101, "dp_d1");
    check("dp_d1_seg", {24'h0, segments_n}, 32'h12);
    wait_sel(4'b0111, "dp_d3");
    check("dp_d3_seg", {24'h0, segments_n}, 32'hC0);
    wait_sel(4'b1101, "dp_d1_again");
    bus_write(2'd1, 32'h20);
    @(negedge clk); #2;
    check("disable_sel", {28'h0, digit_sel_n}, 32'hF);
    check("disable_seg", {24'h0, segments_n}, 32'hFF);
    read_lit(2'd2, "disable_status", 32'hFFFF_FFFF, 32'h0);
    read_lit(2'd3, "blink_reg_init", 32'hFFFF_FFFF, 32'h0);

`ifdef HEX_DISPLAY_BLINK_EN
    bus_write(2'd0, 32'h1234);
    bus_write(2'd3, 32'h2);
    read_lit(2'd3, "blink_reg", 32'hFFFF_FFFF, 32'h2);
    bus_write(2'd1, 32'h1);
    lit = 0;
    repeat (256) begin
      @(negedge clk); #2;
      if (digit_sel_n != 4'hF) lit++;
    end
    check("blink_lit_cycles", lit, 96);
    bus_write(2'd3, 32'h0);
    repeat (4) @(negedge clk);
    lit = 0;
    repeat (256) begin
      @(negedge clk); #2;
      if (digit_sel_n != 4'hF) lit++;
    end
    check("steady_lit_cycles", lit, 192);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r  = int'($urandom_range(0, 15));
      ra = 2'($urandom_range(0, 3));
      rd = $urandom;
      if (ra == 2'd1) rd[0] = ($urandom_range(0, 7) != 0);
      if (ra == 2'd3) rd = 32'($urandom_range(0, 3));
      if (r == 0) begin
        bus_write(ra, rd);
      end else if (r == 1) begin
        @(negedge clk); #1;
        address = ra; writedata = rd; chipselect = 1'b0; write_n = 1'b0;
        @(posedge clk); #1;
        write_n = 1'b1;
      end else if (r < 5) begin
        bus_read(ra);
      end else begin
        @(posedge clk);
      end
    end
    for (int a = 0; a < 4; a++) bus_read(2'(a));

    @(negedge clk);
    check_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
